regfile_wr_arbiter: RTL and testbench

//  Shares the register file's single write port (WE3/A3/WD3) between two writers:
//  - the pipeline writeback stage (primary);
//  - a multi-cycle long-latency unit, such as mul/div or a load miss (secondary, valid/ready).

---
 rtl/regfile_wr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Shares the register file's single write port (WE3/A3/WD3) between the
// pipeline writeback stage (primary) and a long-latency unit such as mul/div
// or a load miss (secondary, valid/ready). Secondary results wait in a small
// FIFO; destinations held in that FIFO are reported to the hazard unit so
// decode can stall on RAW/WAW against queued results.
//
// Optional feature macro: WB_ARB_STARVE_GUARD_EN
//   defined     : a starvation counter forces one FIFO drain cycle (wb_stall=1)
//                 after STARVE_MAX consecutive cycles of the pipeline winning
//                 while the FIFO holds results.
//   not defined : strict pipeline priority, wb_stall tied low, no counter.
//
// Parameters
//   XLEN        data width
//   FIFO_DEPTH  secondary result FIFO entries (power of 2, >= 2)
//   STARVE_MAX  consecutive blocked cycles before the starvation guard fires
//
// Ports
//   clk        in   clock, all state updates on posedge
//   rst_n      in   synchronous active-low reset
//   wb_we      in   pipeline writeback request
//   wb_rd      in   pipeline destination register
//   wb_data    in   pipeline writeback data
//   wb_stall   out  hold WB stage this cycle (registered)
//   lu_valid   in   long-latency result valid
//   lu_rd      in   long-latency destination register
//   lu_data    in   long-latency result data
//   lu_ready   out  FIFO can accept (depends on current occupancy only)
//   rf_we      out  regfile WE3 (registered)
//   rf_a3      out  regfile A3 (registered)
//   rf_wd      out  regfile WD3 (registered)
//   q_a1       in   hazard query address 1 (decode rs1)
//   q_a2       in   hazard query address 2 (decode rs2)
//   pend_hit1  out  a queued FIFO entry targets q_a1 (q_a1 != 0), combinational
//   pend_hit2  out  a queued FIFO entry targets q_a2 (q_a2 != 0), combinational
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_stall,
    input  logic            lu_valid,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_ready,
    output logic            rf_we,
    output logic [4:0]      rf_a3,
    output logic [XLEN-1:0] rf_wd,
    input  logic [4:0]      q_a1,
    input  logic [4:0]      q_a2,
    output logic            pend_hit1,
    output logic            pend_hit2
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Elaboration-time parameter sanity checks.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("regfile_wr_arbiter: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (STARVE_MAX < 1) begin : g_bad_starve
        $error("regfile_wr_arbiter: STARVE_MAX must be >= 1");
    end

    // FIFO storage (data only, never reset) and control state.
    logic [4:0]            fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0]       fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic fifo_empty;
    logic push;
    logic enq;
    logic wb_grant;
    logic pop;

    // ---- Stage 0: arbitration on current inputs and FIFO state ----
    always_comb begin
        fifo_empty = (count == '0);
        lu_ready   = (count < CNT_W'(FIFO_DEPTH));
        push       = lu_valid && lu_ready;
        // x0 results complete the handshake but never occupy a slot.
        enq        = push && (lu_rd != 5'd0);
        // wb_stall is registered, so this never forms a loop through WB.
        wb_grant   = wb_we && (wb_rd != 5'd0) && !wb_stall;
        // Pop decision uses occupancy before this cycle's push: no bypass.
        pop        = !wb_grant && !fifo_empty;
    end

    // Hazard lookup over queued entries only; the registered in-flight
    // write is already visible to the regfile's own forwarding path.
    always_comb begin
        pend_hit1 = 1'b0;
        pend_hit2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_rd[i] == q_a1)) pend_hit1 = 1'b1;
            if (fifo_vld[i] && (fifo_rd[i] == q_a2)) pend_hit2 = 1'b1;
        end
        if (q_a1 == 5'd0) pend_hit1 = 1'b0;
        if (q_a2 == 5'd0) pend_hit2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wr_ptr]   <= lu_rd;
            fifo_data[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_vld <= '0;
        end else begin
            // Slots touched by pop and enq differ whenever both fire,
            // because enq with a non-empty FIFO cannot reach the head slot.
            if (pop) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_W'(1);
            end
            if (enq) begin
                fifo_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            case ({enq, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ---- Stage 1: registered write port toward regfile_p ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_a3 <= 5'd0;
            rf_wd <= '0;
        end else begin
            rf_we <= wb_grant || pop;
            if (wb_grant) begin
                rf_a3 <= wb_rd;
                rf_wd <= wb_data;
            end else if (pop) begin
                rf_a3 <= fifo_rd[rd_ptr];
                rf_wd <= fifo_data[rd_ptr];
            end
        end
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [SC_W-1:0] starve_cnt;
    logic [SC_W-1:0] starve_inc;

    assign starve_inc = starve_cnt + SC_W'(1);

    // Counts cycles where queued results lose to the pipeline. Reaching
    // STARVE_MAX raises wb_stall for exactly one cycle; in that cycle the
    // pipeline cannot win, the head pops and the count returns to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            wb_stall <= 1'b0;
            if (pop) begin
                starve_cnt <= '0;
            end else if (wb_grant && !fifo_empty) begin
                starve_cnt <= starve_inc;
                wb_stall   <= (starve_inc == SC_W'(STARVE_MAX));
            end
        end
    end
`else
    assign wb_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Scoreboard bench for regfile_wr_arbiter. A driver applies directed and
// random stimulus on the falling edge, checks the combinational outputs
// against a queue-based reference model, and pushes the expected register
// write (tagged with the cycle it must appear) into a scoreboard queue. An
// independent monitor pops and compares whenever rf_we is presented.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    localparam int XLEN       = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;

    logic            clk;
    logic            rst_n;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_stall;
    logic            lu_valid;
    logic [4:0]      lu_rd;
    logic [XLEN-1:0] lu_data;
    logic            lu_ready;
    logic            rf_we;
    logic [4:0]      rf_a3;
    logic [XLEN-1:0] rf_wd;
    logic [4:0]      q_a1;
    logic [4:0]      q_a2;
    logic            pend_hit1;
    logic            pend_hit2;

    regfile_wr_arbiter #(
        .XLEN      (XLEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .wb_stall (wb_stall),
        .lu_valid (lu_valid),
        .lu_rd    (lu_rd),
        .lu_data  (lu_data),
        .lu_ready (lu_ready),
        .rf_we    (rf_we),
        .rf_a3    (rf_a3),
        .rf_wd    (rf_wd),
        .q_a1     (q_a1),
        .q_a2     (q_a2),
        .pend_hit1(pend_hit1),
        .pend_hit2(pend_hit2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int              tag;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    wr_t  expq[$];     // scoreboard: expected regfile writes
    ent_t mq[$];       // reference model of the secondary FIFO
    int   starve   = 0;
    bit   m_stall  = 1'b0;
    bit   model_ok = 1'b0;
    logic [4:0]      hold_a3 = 5'd0;
    logic [XLEN-1:0] hold_wd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus plus the reference model update.
    task automatic step(input logic r, input logic we, input logic [4:0] rd,
                        input logic [XLEN-1:0] wd, input logic lv,
                        input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                        input logic [4:0] a1, input logic [4:0] a2);
        int   n;
        bit   ready;
        bit   hit1;
        bit   hit2;
        bit   grant;
        bit   popped;
        wr_t  w;
        ent_t e;
        @(negedge clk);
        rst_n    = r;
        wb_we    = we;
        wb_rd    = rd;
        wb_data  = wd;
        lu_valid = lv;
        lu_rd    = lrd;
        lu_data  = ld;
        q_a1     = a1;
        q_a2     = a2;
        #1;
        n     = mq.size();
        ready = (n < FIFO_DEPTH);
        hit1  = 1'b0;
        hit2  = 1'b0;
        foreach (mq[i]) begin
            if (a1 != 5'd0 && mq[i].rd == a1) hit1 = 1'b1;
            if (a2 != 5'd0 && mq[i].rd == a2) hit2 = 1'b1;
        end
        if (model_ok) begin
            chk("lu_ready", 64'(lu_ready), 64'(ready));
            chk("pend_hit1", 64'(pend_hit1), 64'(hit1));
            chk("pend_hit2", 64'(pend_hit2), 64'(hit2));
            chk("wb_stall", 64'(wb_stall), 64'(m_stall));
        end
        if (!r) begin
            mq.delete();
            starve   = 0;
            m_stall  = 1'b0;
            hold_a3  = 5'd0;
            hold_wd  = '0;
            model_ok = 1'b1;
        end else begin
            grant  = we && (rd != 5'd0) && !m_stall;
            popped = 1'b0;
            w.tag  = cyc + 1;
            if (grant) begin
                w.rd   = rd;
                w.data = wd;
                expq.push_back(w);
            end else if (n > 0) begin
                e      = mq.pop_front();
                w.rd   = e.rd;
                w.data = e.data;
                expq.push_back(w);
                popped = 1'b1;
            end
            if (lv && ready && lrd != 5'd0) begin
                e.rd   = lrd;
                e.data = ld;
                mq.push_back(e);
            end
`ifdef WB_ARB_STARVE_GUARD_EN
            if (popped) begin
                starve  = 0;
                m_stall = 1'b0;
            end else if (grant && n > 0) begin
                starve  = starve + 1;
                m_stall = (starve >= STARVE_MAX);
            end else begin
                m_stall = 1'b0;
            end
`else
            m_stall = 1'b0;
`endif
        end
    endtask

    // Monitor: compares every presented write against the scoreboard and
    // flags writes that were due but never appeared.
    initial begin
        wr_t w;
        forever begin
            @(posedge clk);
            #1;
            if (rf_we === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write at cycle %0d: got a3=%0d wd=%0h expected no write",
                             cyc, rf_a3, rf_wd);
                end else begin
                    w = expq.pop_front();
                    chk("write_cycle", 64'(cyc), 64'(w.tag));
                    chk("rf_a3", 64'(rf_a3), 64'(w.rd));
                    chk("rf_wd", 64'(rf_wd), 64'(w.data));
                    hold_a3 = w.rd;
                    hold_wd = w.data;
                end
            end else begin
                chk("rf_we_low", 64'(rf_we), 64'(0));
                if (expq.size() > 0 && expq[0].tag <= cyc) begin
                    w = expq.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_write at cycle %0d: got no write expected a3=%0d wd=%0h",
                             cyc, w.rd, w.data);
                end
                chk("rf_a3_hold", 64'(rf_a3), 64'(hold_a3));
                chk("rf_wd_hold", 64'(rf_wd), 64'(hold_wd));
            end
        end
    end

    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    endtask

    initial begin
        logic            r_r, r_we, r_lv;
        logic [4:0]      r_rd, r_lrd, r_a1, r_a2;
        logic [XLEN-1:0] r_wd, r_ld;

        rst_n    = 1'b0;
        wb_we    = 1'b0;
        wb_rd    = 5'd0;
        wb_data  = '0;
        lu_valid = 1'b1;
        lu_rd    = 5'd7;
        lu_data  = 32'h55;
        q_a1     = 5'd7;
        q_a2     = 5'd7;

        // Reset held with lu_valid asserted: nothing may enter the FIFO.
        repeat (3) step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h55, 5'd7, 5'd7);
        step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd7, 5'd7);
        chk("reset_rf_we", 64'(rf_we), 64'(0));
        chk("reset_rf_a3", 64'(rf_a3), 64'(0));
        chk("reset_rf_wd", 64'(rf_wd), 64'(0));

        // Plain pipeline write.
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0, 5'd0, 5'd0);
        idle(2);

        // Secondary push while WB idle, hazard visible while queued.
        step(1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h1234, 5'd7, 5'd0);
        step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd7, 5'd7);
        step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd7, 5'd7);

        // x0 on both sides: no write, no FIFO occupancy.
        step(1'b1, 1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB, 5'd0, 5'd0);
        idle(2);

        // Fill the FIFO behind a busy pipeline; starvation behaviour.
        step(1'b1, 1'b1, 5'd1, 32'h100, 1'b1, 5'd3, 32'h3333, 5'd3, 5'd4);
        step(1'b1, 1'b1, 5'd2, 32'h200, 1'b1, 5'd4, 32'h4444, 5'd3, 5'd4);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 5'(8 + i), 32'(i), 1'b1, 5'd6, 32'h6666, 5'd3, 5'd4);
        idle(4);

        // Queued entry dropped by a one-cycle reset.
        step(1'b1, 1'b1, 5'd9, 32'h999, 1'b1, 5'd6, 32'h6060, 5'd6, 5'd0);
        step(1'b0, 1'b1, 5'd10, 32'hA0A, 1'b0, 5'd0, '0, 5'd6, 5'd0);
        idle(4);

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            r_r  = ($urandom_range(0, 199) != 0);
            r_we = ($urandom_range(0, 9) < 7);
            r_rd = 5'($urandom_range(0, 7));
            r_wd = $urandom();
            r_lv = ($urandom_range(0, 1) == 1);
            r_lrd = 5'($urandom_range(0, 7));
            r_ld = $urandom();
            r_a1 = 5'($urandom_range(0, 7));
            r_a2 = 5'($urandom_range(0, 7));
            step(r_r, r_we, r_rd, r_wd, r_lv, r_lrd, r_ld, r_a1, r_a2);
        end

        for (int k = 0; k < 20 && mq.size() > 0; k++) idle(1);
        idle(3);
        chk("scoreboard_drained", 64'(expq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
